// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending scoreboard, optional write-to-read
// forwarding and a sequential soft-clear engine.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy1,
    output logic              busy2,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nx;
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic w_idle;
    logic w_clr_go;
    logic w_wr_en;
    logic w_iss_en;
    logic w_fwd1;
    logic w_fwd2;

    assign w_idle = (r_state == S_IDLE);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_clr_go   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nx = S_CLEAR;
                    w_cnt_nx   = ADDR_W'(1);
                    w_clr_go   = 1'b1;
                end
            end
            S_CLEAR: begin
                if (r_cnt == '1) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // An accepted clear swallows any write or issue in the same cycle
    assign w_wr_en  = we && (waddr != '0) && w_idle && !clr_req;
    assign w_iss_en = issue_valid && (issue_addr != '0) && w_idle && !clr_req;

    assign w_fwd1 = BYPASS && we && (waddr != '0) && w_idle && (waddr == raddr1);
    assign w_fwd2 = BYPASS && we && (waddr != '0) && w_idle && (waddr == raddr2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end else if (!w_idle) begin
            r_regs[r_cnt] <= '0;
        end
    end

    // Issue is applied after the write clear so a same-cycle producer wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if (w_clr_go) begin
            r_pend <= '0;
        end else begin
            if (w_wr_en) begin
                r_pend[waddr] <= 1'b0;
            end
            if (w_iss_en) begin
                r_pend[issue_addr] <= 1'b1;
            end
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : (w_fwd1 ? wdata : r_regs[raddr1]);
    assign rdata2 = (raddr2 == '0) ? '0 : (w_fwd2 ? wdata : r_regs[raddr2]);

    assign busy1 = (raddr1 != '0) && r_pend[raddr1] && !w_fwd1;
    assign busy2 = (raddr2 != '0) && r_pend[raddr2] && !w_fwd2;

    assign clr_busy = (r_state == S_CLEAR);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: four instances (ADDR_W 5/3, BYPASS 1/0)
// on shared stimulus, checked against an array/pending-bit model.
module tb_regfile_scoreboard;

    localparam int NI = 4;
    localparam int AW [NI] = '{5, 5, 3, 3};
    localparam bit BY [NI] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic        iv = 1'b0;
    logic [4:0]  ia = '0;
    logic        clr_req = 1'b0;

    logic [31:0] rd1 [NI];
    logic [31:0] rd2 [NI];
    logic        bz1 [NI];
    logic        bz2 [NI];
    logic        cb  [NI];

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    logic [31:0] m_regs [NI][32];
    bit          m_pend [NI][32];
    bit          m_clr  [NI];
    int          m_cnt  [NI];

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]), .rdata2(rd2[0]),
        .issue_valid(iv), .issue_addr(ia), .busy1(bz1[0]), .busy2(bz2[0]),
        .clr_req(clr_req), .clr_busy(cb[0]));

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]), .rdata2(rd2[1]),
        .issue_valid(iv), .issue_addr(ia), .busy1(bz1[1]), .busy2(bz2[1]),
        .clr_req(clr_req), .clr_busy(cb[1]));

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(3), .BYPASS(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr[2:0]), .wdata(wdata),
        .raddr1(raddr1[2:0]), .raddr2(raddr2[2:0]), .rdata1(rd1[2]),
        .rdata2(rd2[2]), .issue_valid(iv), .issue_addr(ia[2:0]),
        .busy1(bz1[2]), .busy2(bz2[2]), .clr_req(clr_req), .clr_busy(cb[2]));

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(3), .BYPASS(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr[2:0]), .wdata(wdata),
        .raddr1(raddr1[2:0]), .raddr2(raddr2[2:0]), .rdata1(rd1[3]),
        .rdata2(rd2[3]), .issue_valid(iv), .issue_addr(ia[2:0]),
        .busy1(bz1[3]), .busy2(bz2[3]), .clr_req(clr_req), .clr_busy(cb[3]));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int msk(int k, logic [4:0] a);
        return int'(a) & ((1 << AW[k]) - 1);
    endfunction

    function automatic bit fwd(int k, logic [4:0] ra);
        return BY[k] && we && msk(k, waddr) != 0 && !m_clr[k] &&
               msk(k, waddr) == msk(k, ra);
    endfunction

    function automatic logic [31:0] exp_rd(int k, logic [4:0] ra);
        if (msk(k, ra) == 0) return 32'h0;
        if (fwd(k, ra)) return wdata;
        return m_regs[k][msk(k, ra)];
    endfunction

    function automatic logic exp_bz(int k, logic [4:0] ra);
        return msk(k, ra) != 0 && m_pend[k][msk(k, ra)] && !fwd(k, ra);
    endfunction

    // Reference model: plain arrays updated from the behavioural rules
    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int k = 0; k < NI; k++) begin
            int d;
            int wa;
            int im;
            d  = 1 << AW[k];
            wa = msk(k, waddr);
            im = msk(k, ia);
            if (!rst_n) begin
                for (int j = 0; j < 32; j++) begin
                    m_regs[k][j] = 32'h0;
                    m_pend[k][j] = 1'b0;
                end
                m_clr[k] = 1'b0;
                m_cnt[k] = 0;
            end else if (m_clr[k]) begin
                m_regs[k][m_cnt[k]] = 32'h0;
                if (m_cnt[k] == d - 1) m_clr[k] = 1'b0;
                else m_cnt[k] = m_cnt[k] + 1;
            end else if (clr_req) begin
                for (int j = 0; j < 32; j++) m_pend[k][j] = 1'b0;
                m_clr[k] = 1'b1;
                m_cnt[k] = 1;
            end else begin
                if (we && wa != 0) begin
                    m_regs[k][wa] = wdata;
                    m_pend[k][wa] = 1'b0;
                end
                if (iv && im != 0) m_pend[k][im] = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && chk_on) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("rdata1[u%0d]", k), rd1[k], exp_rd(k, raddr1));
                chk($sformatf("rdata2[u%0d]", k), rd2[k], exp_rd(k, raddr2));
                chk($sformatf("busy1[u%0d]", k), 32'(bz1[k]), 32'(exp_bz(k, raddr1)));
                chk($sformatf("busy2[u%0d]", k), 32'(bz2[k]), 32'(exp_bz(k, raddr2)));
                chk($sformatf("clr_busy[u%0d]", k), 32'(cb[k]), 32'(m_clr[k]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        we = 1'b0;
        iv = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic preload();
        for (int i = 1; i < 32; i++) begin
            we = 1'b1;
            waddr = 5'(i);
            wdata = 32'(i);
            step();
        end
        quiet();
    endtask

    task automatic count_clear(input int exp0, input int exp2, input string nm);
        int n0;
        int n2;
        n0 = 0;
        n2 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (cb[0]) n0++;
            if (cb[2]) n2++;
            if (c == 5) begin
                we = 1'b1;
                waddr = 5'd3;
                wdata = 32'h3333_3333;
                iv = 1'b1;
                ia = 5'd3;
                clr_req = 1'b1;
            end else if (c == 6) begin
                quiet();
            end
        end
        chk({nm, "_len_aw5"}, 32'(n0), 32'(exp0));
        chk({nm, "_len_aw3"}, 32'(n2), 32'(exp2));
    endtask

    initial begin
        raddr1 = 5'd5;
        raddr2 = 5'd31;
        repeat (3) step();
        chk("rst_rd1", rd1[0], 32'h0);
        chk("rst_busy1", 32'(bz1[0]), 32'h0);
        chk("rst_clr_busy", 32'(cb[0]), 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        chk_on = 1'b1;
        step();

        // Forwarding vs registered read
        we = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEAD_BEEF;
        raddr1 = 5'd5;
        neg();
        chk("fwd_byp1", rd1[0], 32'hDEAD_BEEF);
        chk("fwd_byp0_old", rd1[1], 32'h0);
        step();
        quiet();
        neg();
        chk("fwd_byp0_next", rd1[1], 32'hDEAD_BEEF);
        step();

        // Register zero is inert
        we = 1'b1;
        waddr = 5'd0;
        wdata = 32'h1234;
        iv = 1'b1;
        ia = 5'd0;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        step();
        quiet();
        neg();
        chk("r0_rd1", rd1[0], 32'h0);
        chk("r0_busy1", 32'(bz1[0]), 32'h0);
        chk("r0_busy2_b0", 32'(bz2[1]), 32'h0);
        step();

        // Scoreboard set / clear / same-cycle issue+write
        iv = 1'b1;
        ia = 5'd7;
        step();
        quiet();
        raddr2 = 5'd7;
        neg();
        chk("sb_set_b1", 32'(bz2[0]), 32'h1);
        chk("sb_set_b0", 32'(bz2[1]), 32'h1);
        step();
        we = 1'b1;
        waddr = 5'd7;
        wdata = 32'hA5;
        neg();
        chk("sb_wr_b1", 32'(bz2[0]), 32'h0);
        chk("sb_wr_b0", 32'(bz2[1]), 32'h1);
        step();
        quiet();
        neg();
        chk("sb_after_b0", 32'(bz2[1]), 32'h0);
        chk("sb_data_b0", rd2[1], 32'hA5);
        step();
        iv = 1'b1;
        ia = 5'd7;
        we = 1'b1;
        waddr = 5'd7;
        wdata = 32'h5A;
        step();
        quiet();
        neg();
        chk("sb_same_b1", 32'(bz2[0]), 32'h1);
        chk("sb_same_b0", 32'(bz2[1]), 32'h1);
        chk("sb_same_data", rd2[0], 32'h5A);
        step();

        // Soft clear with a same-cycle write/issue and a mid-clear write
        preload();
        raddr1 = 5'd3;
        raddr2 = 5'd20;
        neg();
        chk("pre_rd20", rd2[0], 32'd20);
        step();
        clr_req = 1'b1;
        we = 1'b1;
        waddr = 5'd4;
        wdata = 32'hFFFF;
        iv = 1'b1;
        ia = 5'd9;
        step();
        quiet();
        count_clear(31, 7, "clr");
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            neg();
            chk($sformatf("clr_rd_%0d", i), rd1[0], 32'h0);
            chk($sformatf("clr_bz_%0d", i), 32'({bz1[0], bz2[0], bz1[2]}), 32'h0);
        end

        // Reset in the middle of a clear
        step();
        preload();
        raddr1 = 5'd20;
        clr_req = 1'b1;
        step();
        quiet();
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_clr_busy", 32'(cb[0]), 32'h0);
        chk("rstmid_rd20", rd1[0], 32'h0);
        chk("rstmid_rd20_b0", rd1[1], 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();
        clr_req = 1'b1;
        step();
        quiet();
        count_clear(31, 7, "reclr");

        // Mixed random traffic
        for (int n = 0; n < 600; n++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom);
            wdata = $urandom;
            raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            raddr2 = ($urandom_range(0, 2) == 0) ? ia : 5'($urandom);
            iv = 1'($urandom_range(0, 1));
            ia = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            clr_req = ($urandom_range(0, 79) == 0);
            step();
        end
        quiet();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as the data word width in bits.
REQ-002 The block SHALL take parameter ADDR_W, default 5, as the register address width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL take parameter BYPASS, default 1, where 1 enables write-to-read forwarding and 0 disables it.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 we  in  1  write enable.
REQ-007 waddr  in  ADDR_W  write address.
REQ-008 wdata  in  DATA_W  write data.
REQ-009 raddr1, raddr2  in  ADDR_W each  read addresses.
REQ-010 rdata1, rdata2  out  DATA_W each  read data, combinational.
REQ-011 issue_valid  in  1  marks issue_addr as pending, i.e. awaiting a writeback.
REQ-012 issue_addr  in  ADDR_W  destination register being issued.
REQ-013 busy1, busy2  out  1 each  pending status of raddr1 and raddr2, combinational.
REQ-014 clr_req  in  1  soft-clear request, one-cycle pulse.
REQ-015 clr_busy  out  1  soft clear in progress, registered.

Function
REQ-016 Register 0 SHALL always read 0 and never be pending; writes and issues to address 0 SHALL be ignored.
REQ-017 Reads SHALL be asynchronous: rdataN = regs[raddrN], except in the forwarding case of REQ-018.
REQ-018 With BYPASS=1, we=1, waddr==raddrN, waddr!=0 and clr_busy=0, rdataN SHALL equal wdata in the same cycle.
REQ-019 A write SHALL commit at the rising edge when we=1, waddr!=0 and clr_busy=0; it is ignored when clr_busy=1.
REQ-020 The scoreboard SHALL hold one pending bit per register. It is set at the edge when issue_valid=1, issue_addr!=0 and clr_busy=0. It is cleared at the edge of a committed write to the same address.
REQ-021 If the same address is issued and written in the same cycle, the pending bit SHALL end the cycle set (the new producer wins).
REQ-022 busyN SHALL equal pending[raddrN] when raddrN!=0, and 0 when raddrN==0.
REQ-023 With BYPASS=1, busyN SHALL be 0 whenever REQ-018 forwarding applies to port N.
REQ-024 With BYPASS=0, busyN SHALL reflect only the registered pending bit, and rdataN SHALL reflect only the stored value.
REQ-025 The clear FSM SHALL have two states, IDLE and CLEAR, and a counter of ADDR_W bits.
REQ-026 In IDLE, clr_req=1 SHALL move the FSM to CLEAR with counter=1, and SHALL zero all pending bits at that edge.
REQ-027 On each CLEAR cycle, regs[counter] SHALL be zeroed and the counter incremented.
REQ-028 When counter==DEPTH-1, the register SHALL be zeroed and the FSM SHALL return to IDLE. The clear therefore lasts exactly DEPTH-1 cycles.
REQ-029 clr_busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-030 clr_req during CLEAR SHALL be ignored.
REQ-031 A write or issue in the same cycle clr_req is accepted in IDLE SHALL be dropped; the clear takes priority.
REQ-032 Reads during CLEAR SHALL return stored contents: already-cleared entries read 0 and not-yet-cleared entries read their old value. No forwarding SHALL occur during CLEAR.
REQ-033 The counter SHALL not wrap: it stops at DEPTH-1, and the FSM leaves CLEAR.

Reset
REQ-034 rst_n=0 SHALL asynchronously set all registers to 0, all pending bits to 0, the FSM to IDLE, the counter to 0 and clr_busy to 0.
REQ-035 rst_n asserted mid-clear SHALL abort the clear immediately; after release, the FSM SHALL be in IDLE with all registers zeroed.
REQ-036 After reset release, rdata1, rdata2, busy1 and busy2 SHALL all be 0 for any addresses.

Verification
REQ-037 Write-and-read: we=1, waddr=5, wdata=0xDEADBEEF, raddr1=5 with BYPASS=1 -> rdata1=0xDEADBEEF in the same cycle. With BYPASS=0, rdata1 shows the old value in that cycle and 0xDEADBEEF in the next cycle.
REQ-038 Register 0: write 0x1234 to address 0 and issue address 0 -> rdata=0 and busy=0 in all later cycles.
REQ-039 Scoreboard: issue addr 7, then raddr2=7 -> busy2=1. Write addr 7 with 0xA5 -> busy2=0 in the same cycle (BYPASS=1) or the next cycle (BYPASS=0). Issue and write addr 7 in the same cycle -> busy2=1 afterwards.
REQ-040 Soft clear with ADDR_W=5: preload regs 1..31 with value=index, then pulse clr_req -> clr_busy=1 for exactly 31 cycles. A write to addr 3 during the clear is dropped, all registers end at 0, and all busy outputs are 0.
REQ-041 Reset mid-clear: pulse clr_req, wait 10 cycles, assert rst_n low asynchronously between edges -> clr_busy=0 immediately and all reads return 0. After release, a new clr_req is accepted and lasts 31 cycles.
REQ-042 Random: mixed write, issue and read traffic checked against a reference model of the array and pending bits, for both BYPASS values and with ADDR_W=3 (clear lasting 7 cycles).
